// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Load-use / memory-busy / branch-flush hazard controller for a
//               5-stage MIPS pipeline. Optional perf counters: HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] c_run     = 1'b0;
    localparam logic [0:0] c_lu_wait = 1'b1;
    localparam logic [2:0] c_lu_init = 3'(LOAD_LAT - 1);

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic [2:0] r_lu_cnt;
    logic [2:0] w_next_lu_cnt;
    logic       w_hazard;
    logic       w_lu_stall;

    assign w_hazard = ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // LU_WAIT keeps stalling regardless of what ID currently holds
    assign w_lu_stall = (r_state == c_lu_wait) | w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_run;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_next_state;
            r_lu_cnt <= w_next_lu_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_lu_cnt = r_lu_cnt;
        if (!mem_busy) begin
            case (r_state)
                c_run: begin
                    if (w_hazard && (LOAD_LAT > 1)) begin
                        w_next_state  = c_lu_wait;
                        w_next_lu_cnt = c_lu_init;
                    end
                end
                c_lu_wait: begin
                    w_next_lu_cnt = r_lu_cnt - 3'd1;
                    if (r_lu_cnt == 3'd1) begin
                        w_next_state = c_run;
                    end
                end
                default: begin
                    w_next_state  = c_run;
                    w_next_lu_cnt = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (w_lu_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;
    logic             w_flush_evt;

    assign w_stall_evt = ~mem_busy & w_lu_stall;
    assign w_flush_evt = ~mem_busy & ~w_lu_stall & branch_taken;

    // Both counters saturate at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Scoreboard bench driving LOAD_LAT=1 and LOAD_LAT=3/CNT_W=4
//               instances with shared directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble}
    localparam logic [4:0] NORM  = 5'b11010;
    localparam logic [4:0] STALL = 5'b00011;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] RSTV  = 5'b00111;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b1;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

    logic        pw1, iw1, if1, ew1, eb1;
    logic        pw3, iw3, if3, ew3, eb3;
    logic [15:0] sc1, fc1;
    logic [3:0]  sc3, fc3;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_LAT(1), .REG_W(5), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pw1), .if_id_write(iw1), .if_id_flush(if1),
        .id_ex_write(ew1), .id_ex_bubble(eb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_stall_ctrl #(.LOAD_LAT(3), .REG_W(5), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pw3), .if_id_write(iw3), .if_id_flush(if3),
        .id_ex_write(ew3), .id_ex_bubble(eb3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    typedef struct {
        logic [4:0]  c1;
        logic [4:0]  c3;
        logic [15:0] s1;
        logic [15:0] f1;
        logic [3:0]  s3;
        logic [3:0]  f3;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec      = 0;

    logic [15:0] m_s1 = '0, m_f1 = '0;
    logic [3:0]  m_s3 = '0, m_f3 = '0;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one entry is consumed per cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctrl_lat1", vec, {11'd0, pw1, iw1, if1, ew1, eb1}, {11'd0, e.c1});
            chk("ctrl_lat3", vec, {11'd0, pw3, iw3, if3, ew3, eb3}, {11'd0, e.c3});
            chk("stall_cnt_lat1", vec, sc1, e.s1);
            chk("flush_cnt_lat1", vec, fc1, e.f1);
            chk("stall_cnt_lat3", vec, {12'd0, sc3}, {12'd0, e.s3});
            chk("flush_cnt_lat3", vec, {12'd0, fc3}, {12'd0, e.f3});
            vec++;
        end
    end

    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic mr, input logic [4:0] ert,
                       input logic bt, input logic mb,
                       input logic [4:0] e1, input logic [4:0] e3, input int n = 1);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ur;
            ex_mem_read = mr; ex_rt = ert; branch_taken = bt; mem_busy = mb;
            if (r) begin
                m_s1 = '0; m_f1 = '0; m_s3 = '0; m_f3 = '0;
            end
            e.c1 = e1;
            e.c3 = e3;
            e.s1 = PERF ? m_s1 : 16'd0;
            e.f1 = PERF ? m_f1 : 16'd0;
            e.s3 = PERF ? m_s3 : 4'd0;
            e.f3 = PERF ? m_f3 : 4'd0;
            q.push_back(e);
            if (!r) begin
                if (e1 == STALL && m_s1 != 16'hFFFF) m_s1 = m_s1 + 16'd1;
                if (e1 == FLUSH && m_f1 != 16'hFFFF) m_f1 = m_f1 + 16'd1;
                if (e3 == STALL && m_s3 != 4'hF) m_s3 = m_s3 + 4'd1;
                if (e3 == FLUSH && m_f3 != 4'hF) m_f3 = m_f3 + 4'd1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then release to normal flow
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RSTV, RSTV, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM, NORM, 2);

        // Load-use on Rs; LOAD_LAT=3 keeps stalling after the load leaves EX
        cyc(0, 8, 0, 0, 1, 8, 0, 0, STALL, STALL);
        cyc(0, 8, 0, 0, 0, 8, 0, 0, NORM,  STALL, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, NORM,  NORM);   // $zero destination
        cyc(0, 8, 0, 0, 0, 8, 0, 0, NORM,  NORM);   // not a load

        // Load-use on Rt, gated by id_uses_rt
        cyc(0, 3, 9, 1, 1, 9, 0, 0, STALL, STALL);
        cyc(0, 3, 9, 1, 0, 9, 0, 0, NORM,  STALL, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM);
        cyc(0, 3, 9, 0, 1, 9, 0, 0, NORM,  NORM);

        // mem_busy freezes mid-LU_WAIT and outranks branch
        cyc(0, 8, 0, 0, 1, 8, 0, 0, STALL, STALL);
        cyc(0, 8, 0, 0, 0, 8, 0, 1, FRZ,   FRZ);
        cyc(0, 8, 0, 0, 0, 8, 1, 1, FRZ,   FRZ);
        cyc(0, 8, 0, 0, 0, 8, 0, 0, NORM,  STALL, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM);

        // Branch flush, and branch ignored while stalling
        cyc(0, 0, 0, 0, 0, 0, 1, 0, FLUSH, FLUSH);
        cyc(0, 8, 0, 0, 1, 8, 1, 0, STALL, STALL);
        cyc(0, 8, 0, 0, 0, 8, 1, 0, FLUSH, STALL);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  STALL);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM);

        // Reset in the middle of LU_WAIT abandons the stall
        cyc(0, 8, 0, 0, 1, 8, 0, 0, STALL, STALL);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, RSTV,  RSTV);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM);

        // 20 back-to-back hazard cycles: 4-bit counter saturates at 15
        cyc(0, 8, 0, 0, 1, 8, 0, 0, STALL, STALL, 20);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  STALL);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, NORM,  NORM, 2);

        chk("queue_drained", vec, 16'(q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
